// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential MUL/DIV unit that borrows the core ALU.
package alu_seq_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = 6;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_SLL   = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REMU = 2'b10,
        OP_RSVD = 2'b11
    } req_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/alu_seq_arbiter_if.sv
// Request/response, core datapath and shared-ALU signals of alu_seq_arbiter.
interface alu_seq_arbiter_if;
    import alu_seq_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            resp_illegal;
    logic [XLEN-1:0] core_a;
    logic [XLEN-1:0] core_b;
    logic [3:0]      core_op;
    logic            core_stall;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_res;

    // Environment side: issues requests, owns the core datapath and the ALU.
    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready, core_a, core_b, core_op, alu_res,
        input  req_ready, resp_valid, resp_data, resp_illegal, core_stall, alu_a, alu_b, alu_op
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready, core_a, core_b, core_op, alu_res,
        output req_ready, resp_valid, resp_data, resp_illegal, core_stall, alu_a, alu_b, alu_op
    );

endinterface

// File: rtl/alu_seq_arbiter.sv
// Sequential MUL/DIVU/REMU engine that time-shares the core ALU, stalling the core while busy.
// DIVU/REMU are built only when ALU_SEQ_DIV_EN is defined; otherwise they report illegal.
module alu_seq_arbiter
    import alu_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    alu_seq_arbiter_if.slave   bus
);

    state_e            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    req_op_e           op;
    logic [XLEN-1:0]   opa, opb, acc, rem, quot, result;
    logic              illegal;
    logic              resp_valid, resp_illegal;
    logic [XLEN-1:0]   resp_data;
    logic              entry_illegal, entry_divz, last_iter;
    logic              req_ready, core_stall;
    logic [XLEN-1:0]   alu_a, alu_b;
    logic [3:0]        alu_op;

`ifdef ALU_SEQ_DIV_EN
    logic [XLEN-1:0]   partial;
    logic              ge;

    // Next partial remainder brings in dividend bits MSB first.
    always_comb begin
        partial = {rem[XLEN-2:0], opa[5'(ITER - 1) - cnt[4:0]]};
        ge      = (partial >= opb);
    end
`endif

    // Request classification at the handshake.
    always_comb begin
        entry_illegal = (req_op_e'(bus.req_op) == OP_RSVD);
        entry_divz    = 1'b0;
`ifdef ALU_SEQ_DIV_EN
        entry_divz    = !entry_illegal && (req_op_e'(bus.req_op) != OP_MUL) && (bus.req_b == '0);
`else
        entry_illegal = (req_op_e'(bus.req_op) != OP_MUL);
`endif
    end

    assign last_iter = (cnt == CNT_W'(ITER - 1));

    always_comb begin
        result = acc;
        if (illegal) begin
            result = '0;
        end else begin
            case (op)
                OP_DIVU: result = quot;
                OP_REMU: result = rem;
                default: result = acc;
            endcase
        end
    end

    // Next state and ALU ownership.
    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        core_stall = 1'b1;
        alu_a      = acc;
        alu_b      = opb;
        alu_op     = ALU_ADD;
        case (state)
            S_IDLE: begin
                req_ready  = 1'b1;
                core_stall = 1'b0;
                alu_a      = bus.core_a;
                alu_b      = bus.core_b;
                alu_op     = bus.core_op;
                if (bus.req_valid) begin
                    if (entry_illegal || entry_divz)
                        state_nx = S_DONE;
                    else if (req_op_e'(bus.req_op) == OP_MUL)
                        state_nx = S_MUL;
                    else
                        state_nx = S_DIV;
                end
            end
            S_MUL: begin
                alu_a  = acc;
                alu_b  = opa << cnt[4:0];
                alu_op = ALU_ADD;
                if (last_iter)
                    state_nx = S_DONE;
            end
`ifdef ALU_SEQ_DIV_EN
            S_DIV: begin
                alu_a  = partial;
                alu_b  = opb;
                alu_op = ALU_SUB;
                if (last_iter)
                    state_nx = S_DONE;
            end
`endif
            S_DONE: begin
                if (resp_valid && bus.resp_ready)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            op           <= OP_MUL;
            opa          <= '0;
            opb          <= '0;
            acc          <= '0;
            rem          <= '0;
            quot         <= '0;
            illegal      <= 1'b0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_illegal <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op      <= req_op_e'(bus.req_op);
                        opa     <= bus.req_a;
                        opb     <= bus.req_b;
                        cnt     <= '0;
                        acc     <= '0;
                        rem     <= '0;
                        quot    <= '0;
                        illegal <= entry_illegal;
                        // Divide by zero: quotient all ones, remainder is the dividend.
                        if (entry_divz) begin
                            quot <= '1;
                            rem  <= bus.req_a;
                        end
                    end
                end
                S_MUL: begin
                    if (opb[cnt[4:0]])
                        acc <= bus.alu_res;
                    cnt <= cnt + CNT_W'(1);
                end
`ifdef ALU_SEQ_DIV_EN
                S_DIV: begin
                    rem  <= ge ? bus.alu_res : partial;
                    quot <= {quot[XLEN-2:0], ge};
                    cnt  <= cnt + CNT_W'(1);
                end
`endif
                S_DONE: begin
                    if (!resp_valid) begin
                        resp_valid   <= 1'b1;
                        resp_data    <= result;
                        resp_illegal <= illegal;
                    end else if (bus.resp_ready) begin
                        resp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.core_stall   = core_stall;
    assign bus.alu_a        = alu_a;
    assign bus.alu_b        = alu_b;
    assign bus.alu_op       = alu_op;
    assign bus.resp_valid   = resp_valid;
    assign bus.resp_data    = resp_data;
    assign bus.resp_illegal = resp_illegal;

endmodule

// File: doc/alu_seq_arbiter.md
ALU_SEQ_ARBITER -- requirements
Module: alu_seq_arbiter

Interface
REQ-001 SHALL have a single clock `clk`, and `rst_n` SHALL be synchronous and active-low.
REQ-002 SHALL expose these ports (name direction width meaning):
- clk  in  1  clock
- rst_n  in  1  sync active-low reset
- req_valid  in  1  multi-cycle op request
- req_ready  out  1  request accepted when high with req_valid
- req_op  in  2  00 MUL(low32), 01 DIVU, 10 REMU, 11 reserved
- req_a / req_b  in  32  operands (unsigned)
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  32  result
- resp_illegal  out  1  op not supported
- core_a / core_b  in  32  single-cycle datapath ALU operands
- core_op  in  4  single-cycle datapath ALU op
- core_stall  out  1  datapath must hold its PC/pipeline
- alu_a / alu_b  out  32  shared ALU operands
- alu_op  out  4  shared ALU op code
- alu_res  in  32  shared ALU result (combinational)

Function
REQ-003 SHALL implement the FSM states IDLE, MUL, DIV and DONE.
REQ-004 In IDLE, the block SHALL drive alu_a/alu_b/alu_op = core_a/core_b/core_op, with core_stall=0 and req_ready=1.
REQ-005 In any state other than IDLE, the block SHALL drive the ALU from internal registers and hold core_stall=1 and req_ready=0.
REQ-006 A handshake (req_valid&req_ready) SHALL latch the op and operands, clear the 6-bit iteration counter, and go to MUL (op 00) or DIV (op 01/10) on the next cycle.
REQ-007 MUL SHALL be shift-add over 32 cycles; each cycle alu_op=ADD, alu_a=acc, alu_b=mcand<<cnt; acc takes alu_res only when multiplier bit[cnt]=1; result SHALL be the low 32 bits (mod 2^32).
REQ-008 DIV SHALL be restoring over 32 cycles:
- per cycle: partial = {rem[30:0], dividend[31-cnt]}; alu_op=SUB, alu_a=partial, alu_b=divisor
- if partial >= divisor (local unsigned compare): rem=alu_res and quotient bit=1
- otherwise: rem=partial and quotient bit=0
REQ-009 After counter value 31, the FSM SHALL go to DONE; resp_valid SHALL first rise exactly 34 cycles after the handshake cycle.
REQ-010 In DONE, resp_valid=1 and resp_data SHALL hold stable until resp_ready=1; on that cycle the FSM SHALL return to IDLE (core_stall drops the next cycle).
REQ-011 DIVU/REMU with req_b=0 SHALL skip DIV and enter DONE directly: DIVU result 0xFFFFFFFF, REMU result req_a, resp_illegal=0.
REQ-012 req_op=11 SHALL enter DONE directly with resp_data=0 and resp_illegal=1.
REQ-013 A req_valid asserted in the same cycle that DONE completes SHALL NOT be accepted until IDLE (req_ready=0 in DONE).
REQ-014 Outputs SHALL be registered except alu_a/alu_b/alu_op/core_stall/req_ready, which decode from the state.

Reset
REQ-015 With rst_n=0 at a clk edge, the block SHALL return to IDLE from any state, aborting any in-flight op with no response.
REQ-016 Reset values SHALL be: resp_valid=0, resp_data=0, resp_illegal=0, counter=0, acc/rem/quotient=0, so core_stall=0 and req_ready=1.

Configuration
REQ-017 Macro ALU_SEQ_DIV_EN: when defined, DIVU/REMU SHALL be implemented per REQ-008/011.
REQ-018 When ALU_SEQ_DIV_EN is undefined, DIV state logic SHALL be absent; op 01/10 SHALL behave as REQ-012 (result 0, resp_illegal=1); MUL is unaffected.

Structure
REQ-019 A shared package alu_seq_pkg SHALL hold:
- ALU op constants: ADD=0000, SUB=1000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, SRA=1101, OR=0110, AND=0111, PASSB=1111
- the req_op enum
- the FSM state enum
- ITER=32
REQ-020 There SHALL be no sub-module; the shared ALU SHALL be instantiated beside this block at the top level and connected via alu_a/alu_b/alu_op/alu_res.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Idle pass-through: core_op=SUB, core_a=5, core_b=9 -> alu_op=1000, alu_res=0xFFFFFFFC same cycle, core_stall=0.
- MUL 7×6 -> resp_valid at handshake+34, resp_data=42, core_stall high throughout; MUL 0xFFFFFFFF×2 -> 0xFFFFFFFE.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF in 2 cycles; REMU 5/0 -> 5.
- Backpressure: resp_ready held 0 for 10 cycles -> resp_data stable, core_stall=1, new req_valid not accepted.
- Reset mid-op: rst_n=0 at iteration 15 -> next cycle IDLE, resp_valid=0, core_stall=0; next MUL 3×3 -> 9.
- Build without ALU_SEQ_DIV_EN: DIVU 100/7 -> resp_data=0, resp_illegal=1 in 2 cycles.
